// File: rtl/vector_pkg.sv
// Shared types for the vector display line engine: coordinate and error types,
// FSM state encoding and a small distance helper.
package vector_pkg;

  localparam int COORD_W = 12;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [COORD_W+1:0] err_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_JUMP,
    ST_DRAW,
    ST_DWELL
  } state_t;

  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? coord_t'(a - b) : coord_t'(b - a);
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham iteration: next beam position and error term from the current
// position, the precomputed deltas and step directions.
module bresenham_step
  import vector_pkg::*;
(
  input  coord_t     cur_x,
  input  coord_t     cur_y,
  input  coord_t     tgt_x,
  input  coord_t     tgt_y,
  input  err_t       dx,
  input  err_t       dy,
  input  err_t       err,
  input  logic       sx_neg,
  input  logic       sy_neg,
  output coord_t     nxt_x,
  output coord_t     nxt_y,
  output err_t       nxt_err,
  output logic       at_target
);

  localparam coord_t ONE = coord_t'(1);

  err_t e2;

  always_comb begin
    e2      = err <<< 1;
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    nxt_err = err;
    // Both tests use the same e2, so a diagonal step applies both corrections.
    if (e2 >= dy) begin
      nxt_err = nxt_err + dy;
      nxt_x   = sx_neg ? coord_t'(cur_x - ONE) : coord_t'(cur_x + ONE);
    end
    if (e2 <= dx) begin
      nxt_err = nxt_err + dx;
      nxt_y   = sy_neg ? coord_t'(cur_y - ONE) : coord_t'(cur_y + ONE);
    end
  end

  assign at_target = (cur_x == tgt_x) && (cur_y == tgt_y);

endmodule

// File: rtl/vector_line_engine.sv
// Jump/draw command responder driving X/Y DAC codes and beam blank.
// Optional endpoint dwell state enabled by defining LINE_DWELL_EN.
module vector_line_engine
  import vector_pkg::*;
#(
  parameter int STEP_DIV     = 4,
  parameter int JUMP_SETTLE  = 64,
  parameter int DWELL_CYCLES = 16
) (
  input  logic   clk,
  input  logic   reset,
  input  coord_t x,
  input  coord_t y,
  input  logic   draw,
  input  logic   jump,
  output logic   ready,
  output coord_t dac_x,
  output coord_t dac_y,
  output logic   blank,
  output logic   dac_strobe
);

  localparam int CNT_MAX_A = (STEP_DIV > JUMP_SETTLE) ? STEP_DIV : JUMP_SETTLE;
  localparam int CNT_MAX   = (CNT_MAX_A > DWELL_CYCLES) ? CNT_MAX_A : DWELL_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STEP_LD   = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(JUMP_SETTLE - 1);
`ifdef LINE_DWELL_EN
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYCLES - 1);
`endif
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  coord_t           dac_x_q, dac_x_d;
  coord_t           dac_y_q, dac_y_d;
  err_t             err_q, err_d;
  logic             blank_q, blank_d;
  logic             strobe_q, strobe_d;
  logic             load_draw;

  coord_t tgt_x_q, tgt_y_q;
  err_t   dx_q, dy_q;
  logic   sx_neg_q, sy_neg_q;

  coord_t adx, ady;
  err_t   setup_dx, setup_dy;

  coord_t nxt_x, nxt_y;
  err_t   nxt_err;
  logic   at_target;

  // Draw setup from the command target and the current beam position
  assign adx      = abs_diff(x, dac_x_q);
  assign ady      = abs_diff(y, dac_y_q);
  assign setup_dx = err_t'({2'b00, adx});
  assign setup_dy = -err_t'({2'b00, ady});

  bresenham_step u_step (
    .cur_x     (dac_x_q),
    .cur_y     (dac_y_q),
    .tgt_x     (tgt_x_q),
    .tgt_y     (tgt_y_q),
    .dx        (dx_q),
    .dy        (dy_q),
    .err       (err_q),
    .sx_neg    (sx_neg_q),
    .sy_neg    (sy_neg_q),
    .nxt_x     (nxt_x),
    .nxt_y     (nxt_y),
    .nxt_err   (nxt_err),
    .at_target (at_target)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dac_x_d   = dac_x_q;
    dac_y_d   = dac_y_q;
    err_d     = err_q;
    blank_d   = blank_q;
    strobe_d  = 1'b0;
    load_draw = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        blank_d = 1'b1;
        if (jump) begin
          state_d  = ST_JUMP;
          cnt_d    = SETTLE_LD;
          dac_x_d  = x;
          dac_y_d  = y;
          strobe_d = 1'b1;
        end else if (draw) begin
          state_d   = ST_DRAW;
          cnt_d     = STEP_LD;
          err_d     = setup_dx + setup_dy;
          blank_d   = 1'b0;
          load_draw = 1'b1;
        end
      end
      ST_JUMP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_DRAW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!at_target) begin
          dac_x_d  = nxt_x;
          dac_y_d  = nxt_y;
          err_d    = nxt_err;
          strobe_d = 1'b1;
          cnt_d    = STEP_LD;
        end else begin
`ifdef LINE_DWELL_EN
          state_d = ST_DWELL;
          cnt_d   = DWELL_LD;
`else
          state_d = ST_IDLE;
          blank_d = 1'b1;
`endif
        end
      end
`ifdef LINE_DWELL_EN
      ST_DWELL: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          blank_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        blank_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dac_x_q  <= '0;
      dac_y_q  <= '0;
      err_q    <= '0;
      blank_q  <= 1'b1;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dac_x_q  <= dac_x_d;
      dac_y_q  <= dac_y_d;
      err_q    <= err_d;
      blank_q  <= blank_d;
      strobe_q <= strobe_d;
    end
  end

  // Line geometry is only meaningful while drawing, so it carries no reset
  always_ff @(posedge clk) begin
    if (load_draw) begin
      tgt_x_q  <= x;
      tgt_y_q  <= y;
      dx_q     <= setup_dx;
      dy_q     <= setup_dy;
      sx_neg_q <= (x < dac_x_q);
      sy_neg_q <= (y < dac_y_q);
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign dac_x      = dac_x_q;
  assign dac_y      = dac_y_q;
  assign blank      = blank_q;
  assign dac_strobe = strobe_q;

endmodule

// File: tb/tb_vector_line_engine.sv
// Scoreboard bench for vector_line_engine: a reference model queues expected DAC
// strobe points and per-command timing; a monitor pops and compares them.
module tb_vector_line_engine;
  import vector_pkg::*;

  localparam int STEP_DIV     = 2;
  localparam int JUMP_SETTLE  = 6;
  localparam int DWELL_CYCLES = 3;
`ifdef LINE_DWELL_EN
  localparam int DWELL_EXTRA = DWELL_CYCLES;
`else
  localparam int DWELL_EXTRA = 0;
`endif
  localparam int WAIT_BUDGET = 20000;

  logic   clk = 1'b0;
  logic   reset;
  coord_t x, y;
  logic   draw, jump;
  logic   ready;
  coord_t dac_x, dac_y;
  logic   blank, dac_strobe;

  vector_line_engine #(
    .STEP_DIV     (STEP_DIV),
    .JUMP_SETTLE  (JUMP_SETTLE),
    .DWELL_CYCLES (DWELL_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .draw       (draw),
    .jump       (jump),
    .ready      (ready),
    .dac_x      (dac_x),
    .dac_y      (dac_y),
    .blank      (blank),
    .dac_strobe (dac_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int blank;} pt_t;
  typedef struct {int busy; int beam; int ex; int ey;} cmd_t;

  pt_t  pt_q[$];
  cmd_t cmd_q[$];

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;
  int cur_x       = 0;
  int cur_y       = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clip(input int v);
    return (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
  endfunction

  // Reference model: classic integer Bresenham walk, timing from the line length
  function automatic void model_draw(input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, cx, cy, len;
    dx  = iabs(x1 - cur_x);
    dy  = -iabs(y1 - cur_y);
    sx  = (cur_x < x1) ? 1 : -1;
    sy  = (cur_y < y1) ? 1 : -1;
    err = dx + dy;
    cx  = cur_x;
    cy  = cur_y;
    while (!(cx == x1 && cy == y1)) begin
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
      pt_q.push_back('{x: cx, y: cy, blank: 0});
    end
    len = (dx > -dy) ? dx : -dy;
    cmd_q.push_back('{busy: (len + 1) * STEP_DIV + DWELL_EXTRA,
                      beam: (len + 1) * STEP_DIV + DWELL_EXTRA, ex: x1, ey: y1});
    cur_x = x1;
    cur_y = y1;
  endfunction

  function automatic void model_jump(input int x1, input int y1);
    pt_q.push_back('{x: x1, y: y1, blank: 1});
    cmd_q.push_back('{busy: JUMP_SETTLE, beam: 0, ex: x1, ey: y1});
    cur_x = x1;
    cur_y = y1;
  endfunction

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Returns at a negedge with ready high; optionally sprays ignored strobes while busy
  task automatic wait_idle(input bit junk);
    int n = 0;
    while (ready !== 1'b1) begin
      if (junk) begin
        draw = 1'($urandom_range(0, 1));
        jump = 1'($urandom_range(0, 1));
        x    = coord_t'($urandom_range(0, 4095));
        y    = coord_t'($urandom_range(0, 4095));
      end
      @(negedge clk);
      n++;
      if (n > WAIT_BUDGET) begin
        vectors++;
        miscompares++;
        $display("FAIL ready_timeout: got ready=%0b after %0d cycles, expected 1", ready, n);
        finish_now();
      end
    end
    draw = 1'b0;
    jump = 1'b0;
  endtask

  task automatic issue(input bit d, input bit j, input int tx, input int ty,
                       input bit junk, input bit wait_done);
    wait_idle(1'b0);
    x    = coord_t'(tx);
    y    = coord_t'(ty);
    draw = d;
    jump = j;
    if (j)      model_jump(tx, ty);
    else if (d) model_draw(tx, ty);
    @(negedge clk);
    draw = 1'b0;
    jump = 1'b0;
    if (wait_done) wait_idle(junk);
  endtask

  // Monitor: checks every DAC latch strobe and each command's busy/beam-on span
  initial begin
    pt_t  p;
    cmd_t c;
    int   busy = 0;
    int   beam = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        busy = 0;
        beam = 0;
      end else begin
        if (dac_strobe) begin
          if (pt_q.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
          end else begin
            p = pt_q.pop_front();
            chk("strobe_x", int'(dac_x), p.x);
            chk("strobe_y", int'(dac_y), p.y);
            chk("strobe_blank", int'(blank), p.blank);
          end
        end
        if (!ready) begin
          busy++;
          if (!blank) beam++;
        end else if (busy > 0) begin
          if (cmd_q.size() == 0) begin
            chk("unexpected_cmd_end", 1, 0);
          end else begin
            c = cmd_q.pop_front();
            chk("busy_cycles", busy, c.busy);
            chk("beam_cycles", beam, c.beam);
            chk("end_x", int'(dac_x), c.ex);
            chk("end_y", int'(dac_y), c.ey);
            chk("idle_blank", int'(blank), 1);
            chk("points_left", pt_q.size(), 0);
          end
          busy = 0;
          beam = 0;
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    draw  = 1'b0;
    jump  = 1'b0;
    x     = '0;
    y     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_dac_x", int'(dac_x), 0);
    chk("rst_dac_y", int'(dac_y), 0);
    chk("rst_blank", int'(blank), 1);
    chk("rst_strobe", int'(dac_strobe), 0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    issue(1'b0, 1'b1, 50, 10, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 10, 0, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 50, 10, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 0, 40, 1'b0, 1'b1);
    // Both strobes together: jump wins; strobes while busy are ignored
    issue(1'b1, 1'b1, 4095, 4095, 1'b1, 1'b1);
    issue(1'b1, 1'b0, 4095, 4095, 1'b1, 1'b1);
    issue(1'b0, 1'b1, 4095, 4095, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 5, 3, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 4090, 4088, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 4095, 4095, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 4095, 4080, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 3, 3, 1'b0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      bit junk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0)
        issue(1'b0, 1'b1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              junk, 1'b1);
      else
        issue(1'b1, 1'b0, clip(cur_x + int'($urandom_range(0, 600)) - 300),
              clip(cur_y + int'($urandom_range(0, 600)) - 300), junk, 1'b1);
    end

    // Reset in the middle of a long draw aborts to the reset values
    issue(1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 4095, 0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("pre_abort_busy", int'(ready), 0);
    mon_en = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(ready), 1);
    chk("abort_blank", int'(blank), 1);
    chk("abort_dac_x", int'(dac_x), 0);
    chk("abort_dac_y", int'(dac_y), 0);
    chk("abort_strobe", int'(dac_strobe), 0);
    reset = 1'b1;
    pt_q.delete();
    cmd_q.delete();
    cur_x  = 0;
    cur_y  = 0;
    mon_en = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 7, 2, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    chk("final_pts_pending", pt_q.size(), 0);
    chk("final_cmds_pending", cmd_q.size(), 0);
    finish_now();
  end

  initial begin
    #5000000;
    vectors++;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_now();
  end

endmodule
